// File: rtl/register_file_mp.sv
// Multi-read-port register file with byte-strobed writes and a sequential clear engine.
// Optional macro REGFILE_BYPASS_EN forwards an accepted write to matching read ports in the same cycle.
module register_file_mp #(
   parameter int WORDSIZE = 64,
   parameter int SIZE     = 32,
   parameter int ADDR_W   = 5,
   parameter int NREAD    = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       write_en,
   input  logic [ADDR_W-1:0]          write_addr,
   input  logic [WORDSIZE-1:0]        write_data,
   input  logic [WORDSIZE/8-1:0]      write_strb,
   input  logic [NREAD*ADDR_W-1:0]    raddr,
   output logic [NREAD*WORDSIZE-1:0]  rdata,
   input  logic                       clear_req,
   output logic                       clear_busy,
   output logic                       clear_done
);

   localparam int NBYTES = WORDSIZE / 8;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SIZE - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t              state;
   state_t              state_next;
   logic [ADDR_W-1:0]   cnt;
   logic                done_q;
   logic [WORDSIZE-1:0] mem [SIZE];
   logic                wr_accept;
   logic [WORDSIZE-1:0] merged;

   // An address is live if it exists and is not the hardwired zero register.
   function automatic logic addr_live(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < (ADDR_W+1)'(SIZE)) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   assign wr_accept = write_en && (state == IDLE) && addr_live(write_addr);

   always_comb begin
      merged = '0;
      if (addr_live(write_addr)) merged = mem[write_addr];
      for (int i = 0; i < NBYTES; i++) begin
         if (write_strb[i]) merged[8*i +: 8] = write_data[8*i +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_next;
         done_q <= (state == CLEAR) && (cnt == LAST_IDX);
         if (state == CLEAR) cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (clear_req) state_next = CLEAR;
         CLEAR:   if (cnt == LAST_IDX) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      clear_busy = (state == CLEAR);
      clear_done = done_q;
   end

   // The clear engine owns the array while running, so writes in CLEAR are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < SIZE; r++) mem[r] <= '0;
      end else if (state == CLEAR) begin
         mem[cnt] <= '0;
      end else if (wr_accept) begin
         mem[write_addr] <= merged;
      end
   end

   for (genvar k = 0; k < NREAD; k++) begin : g_read
      logic [ADDR_W-1:0]   rd_addr;
      logic [WORDSIZE-1:0] rd_word;
      always_comb begin
         rd_addr = raddr[k*ADDR_W +: ADDR_W];
         rd_word = '0;
         if (addr_live(rd_addr)) rd_word = mem[rd_addr];
`ifdef REGFILE_BYPASS_EN
         if (wr_accept && (rd_addr == write_addr)) rd_word = merged;
`else
`endif
         rdata[k*WORDSIZE +: WORDSIZE] = rd_word;
      end
   end

endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 SHALL have parameter WORDSIZE, default 64, data word width in bits (multiple of 8).
REQ-002 SHALL have parameter SIZE, default 32, number of registers (2..2**ADDR_W).
REQ-003 SHALL have parameter ADDR_W, default 5, address width.
REQ-004 SHALL have parameter NREAD, default 2, number of independent read ports (1..4).
REQ-005 SHALL have parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero.
REQ-006 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port write_en  input  1  write request for the current cycle.
REQ-009 SHALL have port write_addr  input  ADDR_W  write target register.
REQ-010 SHALL have port write_data  input  WORDSIZE  write data.
REQ-011 SHALL have port write_strb  input  WORDSIZE/8  byte enables; bit i covers data bits [8i+7:8i].
REQ-012 SHALL have port raddr  input  NREAD*ADDR_W  read addresses; port k at [k*ADDR_W +: ADDR_W].
REQ-013 SHALL have port rdata  output  NREAD*WORDSIZE  read data; port k at [k*WORDSIZE +: WORDSIZE].
REQ-014 SHALL have port clear_req  input  1  start sequential clear of all registers.
REQ-015 SHALL have port clear_busy  output  1  high while clear sequence runs.
REQ-016 SHALL have port clear_done  output  1  one-cycle pulse when clear completes.

Function
REQ-017 Reads SHALL be combinational: rdata port k = contents of register raddr[k], no clock latency.
REQ-018 raddr >= SIZE SHALL read all zeros; write_addr >= SIZE SHALL be ignored.
REQ-019 With ZERO_REG=1, register 0 SHALL always read 0 and writes to it SHALL be ignored.
REQ-020 Write SHALL commit at rising clk edge when write_en=1 and FSM in IDLE: only bytes with write_strb=1 updated, others retained.
REQ-021 write_strb all zero with write_en=1 SHALL leave contents unchanged.
REQ-022 Clear FSM states: IDLE, CLEAR. IDLE->CLEAR on clk edge with clear_req=1; clear_busy=1 in CLEAR.
REQ-023 In CLEAR, an ADDR_W-bit counter SHALL zero register cnt each cycle, cnt from 0 to SIZE-1; SIZE cycles total.
REQ-024 At cnt=SIZE-1 FSM SHALL return to IDLE and clear_done SHALL pulse high the following cycle (first IDLE cycle) only.
REQ-025 write_en during CLEAR SHALL be dropped (no write, no later retry); clear_req during CLEAR SHALL be ignored.
REQ-026 Simultaneous clear_req and write_en in IDLE: the write SHALL commit on that edge, clear starts the same edge (register 0 cleared next edge).
REQ-027 Reads during CLEAR SHALL return current contents (already cleared registers read 0).
REQ-028 Multiple read ports on the same address SHALL return identical data.

Reset
REQ-029 rst_n=0 SHALL immediately, independent of clk, zero all registers, set FSM to IDLE, counter to 0, clear_busy=0, clear_done=0.
REQ-030 Reset asserted mid-clear SHALL abort the sequence; no clear_done pulse SHALL be issued.
REQ-031 After rst_n deasserts, first write SHALL be accepted on the first rising edge with rst_n=1.

Configuration
REQ-032 Macro REGFILE_BYPASS_EN, when defined, SHALL forward: if write_en=1, FSM IDLE, write accepted (REQ-018/019) and raddr[k]=write_addr, rdata port k = stored word with strobed bytes replaced by write_data, same cycle.
REQ-033 Without REGFILE_BYPASS_EN, rdata SHALL show the old value until after the committing edge.

Verification
REQ-034 Reset, write_addr=13, write_data=0x aabb, strb=all 1s, edge; raddr0=13, raddr1=6 -> rdata0=0x...aabb, rdata1=0.
REQ-035 Register 4 = 0xe45fb21f, write 0x11223344_55667788 strb=0x01 -> reads 0x00000000_e45fb288.
REQ-036 Write 0xffff to address 0 (ZERO_REG=1) and to address 31 -> addr 0 reads 0, addr 31 reads 0xffff.
REQ-037 Fill regs 1..31 nonzero, pulse clear_req, write_en held high -> clear_busy 32 cycles, clear_done one cycle, all reads 0, no write lands.
REQ-038 Assert rst_n=0 at clear cycle 10 between edges -> outputs zero immediately, no clear_done, FSM IDLE.
REQ-039 Write 0xaabb to 13 with raddr0=13 before edge -> with REGFILE_BYPASS_EN rdata0=0xaabb pre-edge; without, old value pre-edge and 0xaabb after.
